// File: rtl/dbus_lsu.sv
// Load/store unit: one memory operation at a time between the memory stage
// and the data bus, with alignment checking, byte-lane steering and load extension.
module dbus_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic        flush,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state;
  logic        drop;
  logic        op_write;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [2:0]  op_lo;
  logic        resp_valid_reg;
  logic        misalign_reg;

  // addr_ok carries no information here: the request is held until data_ok.
  logic unused_addr_ok;
  assign unused_addr_ok = dresp_addr_ok;

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      2'd0:    is_aligned = 1'b1;
      2'd1:    is_aligned = (lo[0] == 1'b0);
      2'd2:    is_aligned = (lo[1:0] == 2'b00);
      default: is_aligned = (lo == 3'b000);
    endcase
  endfunction

  function automatic logic [7:0] strobe_of(input logic [1:0] size, input logic [2:0] lo);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    strobe_of = base << lo;
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] data, input logic [2:0] lo,
                                          input logic [1:0] size, input logic uns);
    logic [63:0] t;
    t = data >> {lo, 3'b000};
    case (size)
      2'd0:    extract = uns ? {56'd0, t[7:0]}  : {{56{t[7]}},  t[7:0]};
      2'd1:    extract = uns ? {48'd0, t[15:0]} : {{48{t[15]}}, t[15:0]};
      2'd2:    extract = uns ? {32'd0, t[31:0]} : {{32{t[31]}}, t[31:0]};
      default: extract = t;
    endcase
  endfunction

  assign req_ready = reset && !flush && (state == IDLE);

  // A flush arriving in the response cycle still squashes the pulse.
  assign resp_valid    = resp_valid_reg && !flush;
  assign resp_misalign = misalign_reg && !flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      drop           <= 1'b0;
      op_write       <= 1'b0;
      op_size        <= 2'd0;
      op_unsigned    <= 1'b0;
      op_lo          <= 3'd0;
      dreq_valid     <= 1'b0;
      dreq_addr      <= 64'd0;
      dreq_size      <= 3'd0;
      dreq_strobe    <= 8'd0;
      dreq_data      <= 64'd0;
      resp_valid_reg <= 1'b0;
      misalign_reg   <= 1'b0;
      resp_rdata     <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_write    <= req_write;
            op_size     <= req_size;
            op_unsigned <= req_unsigned;
            op_lo       <= req_addr[2:0];
            drop        <= 1'b0;
            if (is_aligned(req_size, req_addr[2:0])) begin
              state       <= BUSY;
              dreq_valid  <= 1'b1;
              dreq_addr   <= req_addr;
              dreq_size   <= {1'b0, req_size};
              dreq_strobe <= req_write ? strobe_of(req_size, req_addr[2:0]) : 8'h00;
              dreq_data   <= req_wdata << {req_addr[2:0], 3'b000};
            end else begin
              state          <= FAULT;
              resp_valid_reg <= 1'b1;
              misalign_reg   <= 1'b1;
              resp_rdata     <= 64'd0;
            end
          end
        end

        BUSY: begin
          if (flush) begin
            drop <= 1'b1;
          end
          // The bus transaction always runs to data_ok; a flush only drops the result.
          if (dresp_data_ok) begin
            dreq_valid  <= 1'b0;
            dreq_addr   <= 64'd0;
            dreq_size   <= 3'd0;
            dreq_strobe <= 8'd0;
            dreq_data   <= 64'd0;
            drop        <= 1'b0;
            if (flush || drop) begin
              state <= IDLE;
            end else begin
              state          <= RESP;
              resp_valid_reg <= 1'b1;
              resp_rdata     <= op_write ? 64'd0
                                         : extract(dresp_data, op_lo, op_size, op_unsigned);
            end
          end
        end

        RESP, FAULT: begin
          state          <= IDLE;
          resp_valid_reg <= 1'b0;
          misalign_reg   <= 1'b0;
          resp_rdata     <= 64'd0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_lsu.sv
// Self-checking bench for dbus_lsu: directed operations with a response scoreboard.
module tb_dbus_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        flush;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misalign;

  dbus_lsu dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .flush         (flush),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign)
  );

  typedef struct packed {
    logic [63:0] rdata;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   n_push = 0;
  int   n_resp = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      nxt();
      n++;
    end
    if (!req_ready) check({tag, "_ready_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic drive_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [63:0] a, input logic [63:0] wd);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  // One complete operation; lat is the accept-to-data_ok distance in cycles.
  task automatic run_op(input string tag, input logic w, input logic [1:0] sz, input logic u,
                        input logic [63:0] a, input logic [63:0] wd, input logic [63:0] bus,
                        input int lat, input logic exp_mis, input logic [63:0] exp_rd,
                        input logic [7:0] exp_strb, input logic [63:0] exp_dd);
    wait_ready(tag);
    drive_req(w, sz, u, a, wd);
    exp_q.push_back('{rdata: exp_rd, mis: exp_mis});
    n_push++;
    nxt();
    req_valid = 1'b0;
    if (exp_mis) begin
      check({tag, "_dreq_valid"}, dreq_valid, 1'b0);
      check({tag, "_fault_pulse"}, resp_valid, 1'b1);
      nxt();
      check({tag, "_ready_after"}, req_ready, 1'b1);
      check({tag, "_no_dreq"}, dreq_valid, 1'b0);
    end else begin
      check({tag, "_dreq_valid"}, dreq_valid, 1'b1);
      check({tag, "_dreq_addr"}, dreq_addr, a);
      check({tag, "_dreq_size"}, dreq_size, {1'b0, sz});
      check({tag, "_dreq_strobe"}, dreq_strobe, exp_strb);
      if (w) check({tag, "_dreq_data"}, dreq_data, exp_dd);
      for (int i = 1; i < lat; i++) begin
        nxt();
        check({tag, "_hold_valid"}, dreq_valid, 1'b1);
        check({tag, "_hold_addr"}, dreq_addr, a);
        check({tag, "_hold_strobe"}, dreq_strobe, exp_strb);
      end
      dresp_data    = bus;
      dresp_data_ok = 1'b1;
      nxt();
      dresp_data_ok = 1'b0;
      dresp_data    = 64'd0;
      check({tag, "_resp_timing"}, resp_valid, 1'b1);
      check({tag, "_dreq_released"}, dreq_valid, 1'b0);
      nxt();
      check({tag, "_resp_one_cycle"}, resp_valid, 1'b0);
      check({tag, "_ready_after"}, req_ready, 1'b1);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (resp_valid === 1'b1) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_misalign", resp_misalign, e.mis);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'd0; req_wdata = 64'd0; flush = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 64'd0;

    repeat (3) nxt();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_dreq_valid", dreq_valid, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_dreq_strobe", dreq_strobe, 8'd0);
    reset = 1'b1;
    #1;
    check("rst_release_ready", req_ready, 1'b1);

    run_op("lb_sext", 1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 3,
           1'b0, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'd0);
    run_op("lhu", 1'b0, 2'd1, 1'b1, 64'h8000_0006, 64'd0, 64'hBEEF_0000_0000_0000, 1,
           1'b0, 64'h0000_0000_0000_BEEF, 8'h00, 64'd0);
    run_op("sw", 1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'h0000_0000_1234_5678, 64'hDEAD_BEEF_DEAD_BEEF, 2,
           1'b0, 64'd0, 8'hF0, 64'h1234_5678_0000_0000);
    run_op("lw_sext", 1'b0, 2'd2, 1'b0, 64'h1000_0004, 64'd0, 64'h8765_4321_0000_0000, 1,
           1'b0, 64'hFFFF_FFFF_8765_4321, 8'h00, 64'd0);
    run_op("lwu", 1'b0, 2'd2, 1'b1, 64'h1000_0004, 64'd0, 64'h8765_4321_0000_0000, 2,
           1'b0, 64'h0000_0000_8765_4321, 8'h00, 64'd0);
    run_op("sb_trunc", 1'b1, 2'd0, 1'b0, 64'h2000_0005, 64'h1122_3344_5566_77AB, 64'd0, 1,
           1'b0, 64'd0, 8'h20, 64'h6677_AB00_0000_0000);
    run_op("sd_misalign", 1'b1, 2'd3, 1'b0, 64'h8000_0004, 64'h0123_4567_89AB_CDEF, 64'd0, 1,
           1'b1, 64'd0, 8'h00, 64'd0);
    run_op("lh_misalign", 1'b0, 2'd1, 1'b0, 64'h8000_0001, 64'd0, 64'd0, 1,
           1'b1, 64'd0, 8'h00, 64'd0);

    // Flush in IDLE: nothing may be accepted.
    drive_req(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'd0);
    flush = 1'b1;
    #1;
    check("idle_flush_ready", req_ready, 1'b0);
    nxt();
    check("idle_flush_no_dreq", dreq_valid, 1'b0);
    check("idle_flush_no_resp", resp_valid, 1'b0);
    flush = 1'b0;
    req_valid = 1'b0;
    #1;
    check("idle_flush_ready_back", req_ready, 1'b1);

    // Flush in BUSY: bus transaction completes, result is dropped.
    wait_ready("flush_busy");
    drive_req(1'b0, 2'd2, 1'b0, 64'h8000_0008, 64'd0);
    nxt();
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("busy_flush_ready", req_ready, 1'b0);
    nxt();
    flush = 1'b0;
    check("busy_flush_hold0", dreq_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      nxt();
      check("busy_flush_hold", dreq_valid, 1'b1);
    end
    dresp_data    = 64'h0000_0000_5555_AAAA;
    dresp_data_ok = 1'b1;
    nxt();
    dresp_data_ok = 1'b0;
    dresp_data    = 64'd0;
    check("busy_flush_dreq_drop", dreq_valid, 1'b0);
    check("busy_flush_no_resp", resp_valid, 1'b0);
    check("busy_flush_next_accept", req_ready, 1'b1);
    run_op("after_flush_lbu", 1'b0, 2'd0, 1'b1, 64'h8000_0002, 64'd0, 64'h0000_0000_00C3_0000, 1,
           1'b0, 64'h0000_0000_0000_00C3, 8'h00, 64'd0);

    // Reset in BUSY.
    wait_ready("rst_busy");
    drive_req(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'd0);
    nxt();
    req_valid = 1'b0;
    check("rst_busy_active", dreq_valid, 1'b1);
    reset = 1'b0;
    #1;
    check("rst_busy_ready_low", req_ready, 1'b0);
    nxt();
    check("rst_busy_dreq_valid", dreq_valid, 1'b0);
    check("rst_busy_dreq_addr", dreq_addr, 64'd0);
    check("rst_busy_resp_valid", resp_valid, 1'b0);
    check("rst_busy_ready", req_ready, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_busy_ready_back", req_ready, 1'b1);
    run_op("ld_fresh", 1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 1,
           1'b0, 64'h0123_4567_89AB_CDEF, 8'h00, 64'd0);

    repeat (3) nxt();
    check("resp_count", 64'(n_resp), 64'(n_push));
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dbus_lsu.md
# dbus_lsu

Load/store unit between the pipeline's memory stage and the data bus. Accepts one memory operation at a time from the memory stage, drives the `dbus_req_t` request (valid, addr, size, strobe, data), and holds it until `data_ok`. Returns the load result to the memory stage, shifted and sign- or zero-extended to 64 bits. Detects misaligned accesses and reports them without issuing a bus request. Holds `req_ready` low while busy so the hazard unit can stall F/D/E/M.

## Interface
- No parameters; data width fixed at 64 bits, address width at 64 bits.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-low; `reset==0` at a posedge resets the block.
- `req_valid` in 1: memory stage presents an operation.
- `req_ready` out 1: block accepts an operation this cycle; high only in IDLE, with `reset==1` and `flush==0`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B.
- `req_unsigned` in 1: zero-extend the load result (LBU/LHU/LWU).
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data, LSB-justified.
- `flush` in 1: squash any pending or in-flight operation's response.
- `dreq_valid`, `dreq_addr[63:0]`, `dreq_size[2:0]`, `dreq_strobe[7:0]`, `dreq_data[63:0]` out: fields of `dbus_req_t`.
- `dresp_addr_ok`, `dresp_data_ok` in 1; `dresp_data` in 64: fields of `dbus_resp_t`.
- `resp_valid` out 1: one-cycle pulse; the operation has completed.
- `resp_rdata` out 64: extended load data; 0 for stores and for faults.
- `resp_misalign` out 1: qualifies `resp_valid`; the access was misaligned.

## Operation
- **FSM states:** IDLE, BUSY, RESP, FAULT.
- **Accept.** An operation is accepted in IDLE when `req_valid && req_ready`. The block latches write, size, unsigned, addr and wdata.
- **Alignment check.** An access is aligned when `addr[0]==0` for size 1, `addr[1:0]==0` for size 2, and `addr[2:0]==0` for size 3.
  - Aligned: go to BUSY.
  - Misaligned: go to FAULT.
- **BUSY.**
  - `dreq_valid=1`, and all `dreq_*` fields stay stable until `dresp_data_ok`.
  - `dresp_addr_ok` is ignored. The request is held regardless; `addr_ok` and `data_ok` may arrive in the same cycle or different cycles.
  - On `dresp_data_ok`: register the extracted data and go to RESP.
- **RESP:** `resp_valid=1` for one cycle, then go to IDLE.
- **FAULT:** `resp_valid=1`, `resp_misalign=1`, `resp_rdata=0` for one cycle, then go to IDLE. No bus request is made.
- **Request field encoding.**
  - `dreq_addr` is the full unaligned `req_addr`.
  - `dreq_size = {1'b0, req_size}`.
  - `dreq_strobe`: 0 for loads. For stores, `8'h01`, `8'h03`, `8'h0F` or `8'hFF` (by size) shifted left by `addr[2:0]`.
  - `dreq_data = wdata << (8*addr[2:0])`, truncated to 64 bits.
- **Load extraction.**
  - Compute `t = dresp_data >> (8*addr[2:0])`.
  - Take the low 8/16/32/64 bits of `t`.
  - Extend with the sign of the top kept bit, or with zeros when unsigned. Size 3 passes through unchanged.
- **Flush.**
  - IDLE: `req_ready=0`, nothing is accepted.
  - BUSY: the bus transaction is never abandoned. `dreq_valid` stays high until `data_ok`; then the block returns to IDLE without pulsing `resp_valid`. A drop flag records the flush.
  - RESP or FAULT: `resp_valid` is suppressed that cycle.

## Timing
- **Reset.** While `reset==0` at a posedge, the next state is IDLE and the drop flag clears. All outputs are 0 while `reset==0`, including `req_ready`.
- **Latency.**
  - Accept at cycle N.
  - `dreq_valid` high from N+1.
  - `data_ok` at cycle M ≥ N+1.
  - `resp_valid` at M+1.
  - Zero-wait bus: `resp_valid` at N+2.
  - Misaligned: `resp_valid` at N+1.
- **Throughput.** The next accept happens no earlier than the `resp_valid` cycle + 1, i.e. one cycle after RESP/FAULT. No back-to-back overlap.
- **Registered outputs.** `dreq_*`, `resp_*` and `resp_rdata` are registered. `req_ready` is combinational from state, `flush` and `reset`.
- **Reset mid-operation.** Reset in BUSY returns to IDLE immediately and deasserts `dreq_valid`; the bus owner is reset together with the core.
- **Flush and data_ok together.** `flush` in the same cycle as `data_ok` in BUSY: go to IDLE, no `resp_valid`.

## Test plan
- **LB, sign-extended.** Load, size 0, addr `0x8000_0003`, `dresp_data=0x0000_0000_8000_0000`; `data_ok` 3 cycles after accept.
  - While waiting: `dreq_valid` held with `strobe=0`, `dreq_addr=0x8000_0003`.
  - Then: `resp_rdata=0xFFFF_FFFF_FFFF_FF80`, `resp_valid` one cycle after `data_ok`.
- **LHU, zero-extended.** addr `0x...06`, `dresp_data=0xBEEF_0000_0000_0000` -> `resp_rdata=0x0000_0000_0000_BEEF`.
- **SW.** addr `0x8000_0004`, `wdata=0x1234_5678` -> `dreq_strobe=8'hF0`, `dreq_data=0x1234_5678_0000_0000`, `dreq_size=2`; `resp_rdata=0`.
- **Misaligned SD.** addr `0x8000_0004`, size 3 -> `dreq_valid` never asserts; `resp_valid=1`, `resp_misalign=1` at N+1; `req_ready` high at N+2.
- **Flush in BUSY.** `flush` pulsed 1 cycle after accept, `data_ok` 4 cycles later -> `dreq_valid` held until `data_ok`; no `resp_valid`; next accept one cycle after `data_ok`.
- **Reset in BUSY.** `reset=0` during BUSY -> next cycle `dreq_valid=0` and all outputs 0. After release, `req_ready=1`, and a fresh LD with `dresp_data=0x0123_4567_89AB_CDEF` returns `0x0123_4567_89AB_CDEF`.
